// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: state encodings, frame
// width, counter width and the clocks-per-bit derivation.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;
    localparam int CNT_W     = 12;
    localparam int IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_START = 3'b001,
        S_DATA  = 3'b010,
        S_STOP  = 3'b011,
        S_DONE  = 3'b100
    } uart_state_e;

    // Clocks per bit; a transmitter built from the same two numbers gets the
    // same divider, which is what makes a TX/RX pair interoperate.
    function automatic int clock_divide_f(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: the serial line in, the recovered byte and
// its status strobes out.
interface uart_rx_if;

    logic                                rx;
    logic [uart_rx_pkg::DATA_BITS-1:0]   rx_data_out;
    logic                                rx_active;
    logic                                done_rx;
    logic                                frame_err;

    modport master (
        output rx,
        input  rx_data_out, rx_active, done_rx, frame_err
    );

    modport slave (
        input  rx,
        output rx_data_out, rx_active, done_rx, frame_err
    );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous rx line plus one history flop
// used to find the start-bit falling edge.
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_rx,
    output logic o_rx_s,
    output logic o_fall_edge
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    // All three flops clear to 0, so a line held low out of reset never
    // looks like a high-to-low transition.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a real shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= i_rx;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign o_rx_s      = r_sync;
    assign o_fall_edge = r_hist & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: falling-edge start detect, mid-bit sampling with a
// clk_freq/baud_rate divider, one-cycle done and framing-error strobes.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int clk_freq  = 32000000,
    parameter int baud_rate = 19200
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.slave  bus
);

    // Valid range is 4 <= clock_divide < 4096 so both terminal counts fit the counter.
    localparam int clock_divide = clock_divide_f(clk_freq, baud_rate);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(clock_divide - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((clock_divide - 1) / 2);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    uart_state_e            r_state;
    uart_state_e            w_state_next;
    logic [CNT_W-1:0]       r_count;
    logic [CNT_W-1:0]       w_count_next;
    logic [IDX_W-1:0]       r_index;
    logic [IDX_W-1:0]       w_index_next;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_done;
    logic                   r_ferr;

    logic                   w_rx_s;
    logic                   w_fall_edge;
    logic                   w_half_end;
    logic                   w_bit_end;
    logic                   w_sample;
    logic                   w_load;
    logic                   w_ferr_next;
    logic                   w_rx_active;

    uart_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (bus.rx),
        .o_rx_s      (w_rx_s),
        .o_fall_edge (w_fall_edge)
    );

    assign w_half_end = (r_count == HALF_LAST);
    assign w_bit_end  = (r_count == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fall_edge) w_state_next = S_START;
            S_START: if (w_half_end)  w_state_next = w_rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (w_bit_end && r_index == IDX_LAST) w_state_next = S_STOP;
            S_STOP:  if (w_bit_end)   w_state_next = w_rx_s ? S_DONE : S_IDLE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_next = '0;
        w_index_next = r_index;
        w_sample     = 1'b0;
        w_load       = 1'b0;
        w_ferr_next  = 1'b0;
        w_rx_active  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_index_next = '0;
            end
            S_START: begin
                w_rx_active  = 1'b1;
                w_count_next = w_half_end ? '0 : r_count + CNT_W'(1);
            end
            S_DATA: begin
                w_rx_active  = 1'b1;
                w_count_next = w_bit_end ? '0 : r_count + CNT_W'(1);
                if (w_bit_end) begin
                    w_sample     = 1'b1;
                    w_index_next = (r_index == IDX_LAST) ? '0 : r_index + IDX_W'(1);
                end
            end
            S_STOP: begin
                w_rx_active  = 1'b1;
                w_count_next = w_bit_end ? '0 : r_count + CNT_W'(1);
                w_load       = w_bit_end &  w_rx_s;
                w_ferr_next  = w_bit_end & ~w_rx_s;
            end
            default: begin
                w_index_next = '0;
            end
        endcase
    end

    // Strobes are registered from next-state decode so they stay glitch-free
    // and line up exactly with the DONE state / first IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_index <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_index <= w_index_next;
            if (w_sample) r_shift[r_index] <= w_rx_s;
            if (w_load)   r_data <= r_shift;
            r_done  <= (w_state_next == S_DONE);
            r_ferr  <= w_ferr_next;
        end
    end

    assign bus.rx_data_out = r_data;
    assign bus.rx_active   = w_rx_active;
    assign bus.done_rx     = r_done;
    assign bus.frame_err   = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: frames are built from bytes,
// expected events kept in a queue and compared against what the receiver reports.
module tb_uart_rx;

    localparam int CD = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(
        .clk_freq  (160),
        .baud_rate (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Events are {is_frame_err, rx_data_out at the strobe}.
    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    logic [7:0] last_good;
    int         active_run;
    int         last_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            active_run = 0;
        end else begin
            if (bus.done_rx)   obs_q.push_back({1'b0, bus.rx_data_out});
            if (bus.frame_err) obs_q.push_back({1'b1, bus.rx_data_out});
            if (bus.done_rx || bus.frame_err)
                check("done_ferr_excl", {31'd0, bus.done_rx & bus.frame_err}, 32'd0);
            if (bus.rx_active) begin
                active_run++;
            end else begin
                if (active_run > 0) last_run = active_run;
                active_run = 0;
            end
        end
    end

    task automatic hold(input logic level, input int n);
        bus.rx = level;
        repeat (n) @(negedge clk);
    endtask

    // Reference: a good stop bit delivers the byte; a low stop bit flags an
    // error while the previously delivered byte stays visible.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) begin
            exp_q.push_back({1'b0, b});
            last_good = b;
        end else begin
            exp_q.push_back({1'b1, last_good});
        end
        hold(1'b0, CD);
        for (int i = 0; i < 8; i++) hold(b[i], CD);
        hold(stop_ok, CD);
    endtask

    task automatic glitch(input int n);
        hold(1'b0, n);
        hold(1'b1, CD);
    endtask

    task automatic drain(input string tag);
        hold(1'b1, 24);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < obs_q.size())
                check($sformatf("%s_ev%0d", tag, i), {23'd0, obs_q[i]}, {23'd0, exp_q[i]});
        check({tag, "_hold"}, {24'd0, bus.rx_data_out}, {24'd0, last_good});
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_data"},   {24'd0, bus.rx_data_out}, 32'd0);
        check({tag, "_active"}, {31'd0, bus.rx_active},   32'd0);
        check({tag, "_done"},   {31'd0, bus.done_rx},     32'd0);
        check({tag, "_ferr"},   {31'd0, bus.frame_err},   32'd0);
    endtask

    initial begin
        last_good = 8'h00;
        last_run  = 0;
        rst       = 1'b1;
        bus.rx    = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Single frame after a long idle
        hold(1'b1, 40);
        send_frame(8'hA5, 1'b1);
        drain("normal");
        check("active_len_ok", {31'd0, (last_run >= 150 && last_run <= 154)}, 32'd1);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drain("b2b");

        // Short low pulse must not produce any strobe
        glitch(3);
        drain("glitch");

        send_frame(8'h3C, 1'b0);
        drain("frame_err");

        // Asynchronous reset during bit 4 of 0x5A, line then held low
        hold(1'b0, CD);
        for (int i = 0; i < 4; i++) hold(bit'((8'h5A >> i) & 8'h01), CD);
        hold(1'b1, 8);
        #2 rst = 1'b1;
        bus.rx = 1'b0;
        #1 check_idle_outputs("rst_mid");
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b0, 20);
        check("rst_low_no_start", {31'd0, bus.rx_active}, 32'd0);
        hold(1'b1, 20);
        send_frame(8'h81, 1'b1);
        drain("after_rst");

        // Transmitter-style link: line low while both ends sit in reset
        rst = 1'b1;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        last_good = 8'h00;
        rst = 1'b0;
        hold(1'b0, 30);
        check("tx_reset_no_start", {31'd0, bus.rx_active}, 32'd0);
        hold(1'b1, CD);
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        send_frame(8'h7E, 1'b1);
        drain("loopback");

        // Random mix of good frames, bad stop bits and glitches
        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                glitch($urandom_range(1, 4));
            end else if (kind == 1) begin
                send_frame(8'($urandom), 1'b0);
                hold(1'b1, CD);
            end else begin
                send_frame(8'($urandom), 1'b1);
                hold(1'b1, $urandom_range(0, 20));
            end
            if (n % 10 == 9) drain($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver and direct downstream partner of the team's UART transmitter: consumes the `tx` line and recovers 8N1 bytes (1 start, 8 data LSB-first, 1 stop).
- Samples each bit at mid-bit using the same `clk_freq`/`baud_rate` divider scheme, so a TX/RX pair with equal parameters interoperates.
- Presents each received byte with a one-cycle done strobe and flags framing errors.

Parameters:
- clk_freq, 32000000, system clock frequency in Hz
- baud_rate, 19200, bits per second
- clock_divide (localparam), clk_freq/baud_rate, clocks per bit (1666 at defaults); must be >= 4 and < 4096

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- rx_data_out  output  8  last correctly framed byte, held until the next good byte
- rx_active  output  1  high while in START, DATA or STOP
- done_rx  output  1  one-cycle pulse when rx_data_out is updated
- frame_err  output  1  one-cycle pulse when the stop bit samples low

Behaviour:
- Reset (asynchronous, active-high): all registers clear immediately.
  - rx_data_out=0, done_rx=0, frame_err=0, rx_active=0, state=IDLE, counter=0, bit index=0.
  - Both synchronizer flops and the edge-history flop reset to 0.
- Input conditioning:
  - 2-flop synchronizer on rx, then one history flop.
  - Start is detected on a falling edge only (history=1, sync=0).
  - A line held low out of reset, such as a transmitter in reset driving 0, never starts a frame.
- Counter: 12-bit, counts 0..limit, then wraps to 0.
- FSM states and transitions:
  - IDLE: counter=0, index=0. On falling edge -> START.
  - START: count to (clock_divide-1)/2 (mid start bit).
    - Synced rx still 0 -> DATA, counter=0.
    - Synced rx is 1 (glitch) -> IDLE, no strobe.
  - DATA: count to clock_divide-1; at terminal count sample synced rx into shift bit[index].
    - index<7 -> index+1, stay in DATA.
    - index=7 -> index=0, go to STOP.
  - STOP: count to clock_divide-1, then sample.
    - Sample 1 -> DONE; rx_data_out loads the shift register on the same edge.
    - Sample 0 -> assert frame_err for one cycle, rx_data_out unchanged, go to IDLE.
  - DONE: done_rx=1 for exactly this one cycle -> IDLE.
  - Undefined state encodings -> IDLE.
- Latency:
  - done_rx rises 2 sync cycles + ~(clock_divide-1)/2 + 9*clock_divide + 1 cycles after the rx falling edge.
  - The receiver is back in IDLE before the nominal end of the stop bit, so back-to-back frames with no idle gap are received.
- Simultaneous events: done_rx and frame_err are never high together; rx edges while not in IDLE are ignored.
- Reset mid-frame: abort immediately with no strobe; the next frame needs a fresh falling edge.
- Outputs done_rx and frame_err are registered (glitch-free).

Decomposition:
- Shared include uart_defs.vh holds:
  - rx/tx state encodings (IDLE=3'b000, START=3'b001, DATA=3'b010, STOP=3'b011, DONE=3'b100)
  - the clock_divide derivation macro/function
  - DATA_BITS=8
- One natural sub-module, uart_sync: a 2-flop synchronizer plus history flop, outputs rx_s and fall_edge, asynchronous reset to 0.

Test Plan:
(Bench parameters: clk_freq=160, baud_rate=10, so clock_divide=16; bits driven 16 clocks each.)
- Normal: idle high 40 clk, send 0xA5 -> exactly one done_rx pulse, rx_data_out=8'hA5, frame_err=0, rx_active high ~152 clk.
- Back-to-back: 0x00 then 0xFF with no idle gap -> two done_rx pulses, rx_data_out 8'h00 then 8'hFF.
- Glitch: rx low for 3 clk, then high -> returns to IDLE, no done_rx, no frame_err, rx_data_out unchanged.
- Framing error: send 0x3C with stop bit forced 0 -> frame_err single pulse, no done_rx, rx_data_out keeps previous 8'hFF.
- Reset mid-frame: assert rst asynchronously during bit 4 of 0x5A -> outputs 0 immediately. Then send 0x81 -> rx_data_out=8'h81.
- Loopback: uart_tx (same parameters) tx -> rx, send 0x3C, 0xC3, 0x7E -> matching rx_data_out sequence, one done_rx per byte, no start from the transmitter's low-during-reset line.
